// File: rtl/mg_csa_accum.sv
// Carry-save accumulator feeding the multiplier's prefix CPA. It folds (sum, carry) beats
// through a 4:2 row and presents each group once. Optional out_count port: MG_CSA_ACCUM_CNT_EN.
module mg_csa_accum #(
    parameter int W         = 30,
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_sum,
    input  logic [W-1:0]     in_carry,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     cpa_a,
    output logic [W-1:0]     cpa_b,
    output logic             out_forced
`ifdef MG_CSA_ACCUM_CNT_EN
   ,output logic [CNT_W-1:0] out_count
`endif
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       acc_s_q, acc_s_d;
    logic [W-1:0]       acc_c_q, acc_c_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               forced_q, forced_d;

    logic [W-1:0]       s1, c1, s2, c2;
    logic [CNT_W-1:0]   cnt_inc;
    logic               accept, close;

    // Two full-adder rows; the accumulator is always zero in IDLE, so the
    // first beat of a group needs no special operand selection.
    always_comb begin
        s1 = acc_s_q ^ acc_c_q ^ in_sum;
        c1 = ((acc_s_q & acc_c_q) | (acc_s_q & in_sum) | (acc_c_q & in_sum)) << 1;
        s2 = s1 ^ c1 ^ in_carry;
        c2 = ((s1 & c1) | (s1 & in_carry) | (c1 & in_carry)) << 1;
    end

    assign in_ready   = (state_q != HOLD);
    assign out_valid  = (state_q == HOLD);
    assign cpa_a      = acc_s_q;
    assign cpa_b      = acc_c_q;
    assign out_forced = forced_q;
`ifdef MG_CSA_ACCUM_CNT_EN
    assign out_count  = (state_q == HOLD) ? cnt_q : '0;
`endif

    assign accept  = in_valid && in_ready;
    assign cnt_inc = (state_q == IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
    assign close   = in_last || (cnt_inc == CNT_W'(MAX_BEATS));

    always_comb begin
        state_d  = state_q;
        acc_s_d  = acc_s_q;
        acc_c_d  = acc_c_q;
        cnt_d    = cnt_q;
        forced_d = forced_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    acc_s_d = s2;
                    acc_c_d = c2;
                    cnt_d   = cnt_inc;
                    if (close) begin
                        state_d  = HOLD;
                        forced_d = ~in_last;
                    end else begin
                        state_d  = ACCUM;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d  = IDLE;
                    acc_s_d  = '0;
                    acc_c_d  = '0;
                    cnt_d    = '0;
                    forced_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_s_q  <= '0;
            acc_c_q  <= '0;
            cnt_q    <= '0;
            forced_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_s_q  <= acc_s_d;
            acc_c_q  <= acc_c_d;
            cnt_q    <= cnt_d;
            forced_q <= forced_d;
        end
    end

endmodule
